instr_prefetch: RTL and testbench

- Parametrised instruction prefetch queue between memory space and instruction decoder; replaces the single-word, decoder-driven fetch of the current pipeline.
- Runs ahead of the decoder: issues sequential word reads over a req/ack memory handshake and buffers up to DEPTH instruction words, each tagged with its fetch address.
- On a PC redirect (jump, call, return, interrupt vector) it flushes its contents and restarts fetching at the new address.

---
 rtl/instr_prefetch.sv | 164 ++++++++++++++++
 tb/tb_instr_prefetch.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch.sv
// Instruction prefetch queue: fetches sequential words ahead of the decoder and
// buffers up to DEPTH {pc, instr} pairs; a PC redirect flushes and restarts fetch.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | no request outstanding; issue one as soon as the queue has room
// REQ     | request outstanding for fetch_pc; data is pushed on mem_ack
// DISCARD | request outstanding from before a redirect; its data is dropped
module instr_prefetch #(
  parameter int SIZE    = 16,
  parameter int DEPTH   = 4,
  parameter int PC_STEP = 2,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SIZE-1:0]  RST_VEC,
  input  logic             redir_en,
  input  logic [SIZE-1:0]  redir_pc,
  output logic             mem_req,
  output logic [SIZE-1:0]  mem_addr,
  input  logic             mem_ack,
  input  logic [SIZE-1:0]  mem_rdata,
  output logic             q_valid,
  output logic [SIZE-1:0]  q_instr,
  output logic [SIZE-1:0]  q_pc,
  input  logic             q_pop,
  output logic [CNT_W-1:0] q_count
);

  localparam int PTR_W = CNT_W - 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [SIZE-1:0]  ALIGN_MASK = ~SIZE'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [SIZE-1:0]  fetch_pc, fetch_pc_n;
  logic [SIZE-1:0]  pc_inc;
  logic             mem_req_n;
  logic [SIZE-1:0]  mem_addr_n;

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             push, pop_ok;
  logic [CNT_W-1:0] count_pop, count_post;

  logic [SIZE-1:0]  instr_q [DEPTH];
  logic [SIZE-1:0]  pc_q    [DEPTH];

  // Redirect wins over both push and pop in the same cycle.
  always_comb begin
    pop_ok     = q_pop && (q_count != '0) && !redir_en;
    push       = (state == REQ) && mem_ack && !redir_en;
    count_pop  = q_count - CNT_W'(pop_ok);
    count_post = count_pop + CNT_W'(push);
    pc_inc     = fetch_pc + SIZE'(PC_STEP);
  end

  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    mem_req_n  = mem_req;
    mem_addr_n = mem_addr;

    if (redir_en) begin
      fetch_pc_n = redir_pc & ALIGN_MASK;
    end

    case (state)
      IDLE: begin
        if (!redir_en && (count_pop < DEPTH_C)) begin
          state_n    = REQ;
          mem_req_n  = 1'b1;
          mem_addr_n = fetch_pc;
        end
      end

      REQ: begin
        if (redir_en) begin
          // A request is never withdrawn; without an ack it must be drained.
          if (mem_ack) begin
            state_n   = IDLE;
            mem_req_n = 1'b0;
          end else begin
            state_n = DISCARD;
          end
        end else if (mem_ack) begin
          fetch_pc_n = pc_inc;
          if (count_post < DEPTH_C) begin
            mem_addr_n = pc_inc;
          end else begin
            state_n   = IDLE;
            mem_req_n = 1'b0;
          end
        end
      end

      DISCARD: begin
        if (mem_ack) begin
          state_n   = IDLE;
          mem_req_n = 1'b0;
        end
      end

      default: begin
        state_n   = IDLE;
        mem_req_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RST_VEC & ALIGN_MASK;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      q_count  <= '0;
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
      mem_req  <= mem_req_n;
      mem_addr <= mem_addr_n;
      if (redir_en) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        q_count <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop_ok) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        q_count <= count_post;
      end
    end
  end

  // Storage needs no reset: entries are only observed while q_valid is high.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_q[wr_ptr] <= mem_rdata;
      pc_q[wr_ptr]    <= fetch_pc;
    end
  end

  assign q_valid = (q_count != '0);
  assign q_instr = instr_q[rd_ptr];
  assign q_pc    = pc_q[rd_ptr];

  // Requests are only issued with room left, so a push into a full queue is a bug.
  property p_no_push_when_full;
    @(posedge clk) disable iff (rst) push |-> (q_count != DEPTH_C);
  endproperty
  a_no_push_when_full : assert property (p_no_push_when_full);

endmodule

// File: tb/tb_instr_prefetch.sv
// Bench for instr_prefetch: a queue-based reference model predicts the fetch
// stream and queue contents; directed phases cover fill, redirect, wrap and reset.
module tb_instr_prefetch;

  localparam int SIZE    = 16;
  localparam int DEPTH   = 4;
  localparam int PC_STEP = 2;
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [SIZE-1:0]  rst_vec = 16'hC000;
  logic             redir_en = 1'b0;
  logic [SIZE-1:0]  redir_pc = '0;
  logic             mem_req;
  logic [SIZE-1:0]  mem_addr;
  logic             mem_ack = 1'b0;
  logic [SIZE-1:0]  mem_rdata = '0;
  logic             q_valid;
  logic [SIZE-1:0]  q_instr;
  logic [SIZE-1:0]  q_pc;
  logic             q_pop = 1'b0;
  logic [CNT_W-1:0] q_count;

  always #5 clk = ~clk;

  instr_prefetch #(.SIZE(SIZE), .DEPTH(DEPTH), .PC_STEP(PC_STEP)) dut (
    .clk(clk), .rst(rst), .RST_VEC(rst_vec),
    .redir_en(redir_en), .redir_pc(redir_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .q_valid(q_valid), .q_instr(q_instr), .q_pc(q_pc), .q_pop(q_pop), .q_count(q_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a * 16'd37) ^ 16'h5A3C;
  endfunction

  // Reference model: expected queue contents plus the next fetch address.
  typedef struct { logic [15:0] pc; logic [15:0] instr; } entry_t;
  entry_t      exp_q[$];
  logic [15:0] next_pc = '0;
  bit          stale = 0;
  bit          exp_req_chk = 0;
  bit          exp_req = 0;
  bit          exp_addr_chk = 0;
  logic [15:0] exp_addr = '0;
  int          pops_seen = 0;

  task automatic model_reset(input logic [15:0] vec);
    exp_q.delete();
    next_pc      = vec & 16'hFFFE;
    stale        = 0;
    exp_req_chk  = 1;
    exp_req      = 0;
    exp_addr_chk = 0;
  endtask

  task automatic model_step();
    int sz;
    bit pop_ok;
    sz = exp_q.size();
    chk("q_count", q_count, sz);
    chk("q_valid", q_valid, sz != 0);
    if (sz != 0) begin
      chk("q_pc", q_pc, exp_q[0].pc);
      chk("q_instr", q_instr, exp_q[0].instr);
    end
    if (exp_req_chk) chk("mem_req", mem_req, exp_req);
    if (exp_addr_chk && mem_req) chk("mem_addr", mem_addr, exp_addr);

    pop_ok = q_pop && (sz != 0) && !redir_en;
    if (pop_ok) pops_seen++;
    exp_req_chk  = 1;
    exp_addr_chk = 0;

    if (redir_en) begin
      exp_q.delete();
      next_pc = redir_pc & 16'hFFFE;
      if (mem_req && !mem_ack) begin
        stale = 1; exp_req = 1; exp_addr_chk = 1; exp_addr = mem_addr;
      end else begin
        stale = 0; exp_req = 0;
      end
    end else begin
      if (pop_ok) void'(exp_q.pop_front());
      if (mem_req && !mem_ack) begin
        exp_req = 1; exp_addr_chk = 1; exp_addr = mem_addr;
      end else if (mem_req && stale) begin
        stale = 0; exp_req = 0;
      end else begin
        if (mem_req) begin
          chk("fetch_addr", mem_addr, next_pc);
          exp_q.push_back('{next_pc, mem_word(next_pc)});
          next_pc = next_pc + 16'(PC_STEP);
        end
        exp_req = exp_q.size() < DEPTH;
        exp_addr_chk = 1; exp_addr = next_pc;
      end
    end
  endtask

  // Monitor samples at negedge+3, after every driver has settled.
  always begin
    @(negedge clk);
    #3;
    if (!rst) model_step();
  end

  // Memory responder: ack after cur_lat waiting cycles; hold blocks one address.
  int          pop_mode = 0;     // 0 none, 1 always, 2 random, 3 manual
  bit          lat_rand = 0;
  int          fixed_lat = 0;
  bit          hold = 0;
  logic [15:0] hold_addr = '0;
  int          wait_cnt = 0;
  int          cur_lat = 0;

  always begin
    @(negedge clk);
    #1;
    if (rst) begin
      mem_ack = 0; wait_cnt = 0; cur_lat = fixed_lat;
    end else begin
      if (mem_ack) begin
        wait_cnt = 0;
        cur_lat  = lat_rand ? int'($urandom_range(0, 3)) : fixed_lat;
      end
      if (mem_req && !(hold && mem_addr == hold_addr) && wait_cnt >= cur_lat) begin
        mem_ack = 1; mem_rdata = mem_word(mem_addr);
      end else begin
        mem_ack = 0; mem_rdata = 16'($urandom);
        if (mem_req) wait_cnt++;
      end
    end
  end

  always begin
    @(negedge clk);
    #1;
    case (pop_mode)
      0: q_pop = 0;
      1: q_pop = 1;
      2: q_pop = 1'($urandom_range(0, 1));
      default: ;
    endcase
  end

  task automatic redirect(input logic [15:0] pc);
    @(negedge clk);
    redir_en = 1; redir_pc = pc;
    @(negedge clk);
    redir_en = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    logic [15:0] wrap_pcs [4];
    wrap_pcs[0] = 16'hFFFC; wrap_pcs[1] = 16'hFFFE;
    wrap_pcs[2] = 16'h0000; wrap_pcs[3] = 16'h0002;

    #1 rst = 1;
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_q_valid", q_valid, 0);
    chk("rst_q_count", q_count, 0);
    model_reset(rst_vec);
    repeat (2) @(negedge clk);
    rst = 0;

    // Fill from reset vector with zero-wait memory, no pops.
    repeat (6) @(negedge clk);
    #4;
    chk("fill_count", q_count, 4);
    chk("fill_head_pc", q_pc, 16'hC000);
    chk("full_no_req", mem_req, 0);

    // Single pop frees a slot and the next fetch is issued on the same edge.
    @(negedge clk);
    pop_mode = 3; q_pop = 1;
    @(negedge clk);
    q_pop = 0;
    #4;
    chk("pop1_count", q_count, 3);
    chk("pop1_req", mem_req, 1);
    chk("pop1_addr", mem_addr, 16'hC008);

    // Continuous pop: one word per cycle sustained.
    repeat (3) @(negedge clk);
    pop_mode = 1;
    repeat (4) @(negedge clk);
    pops_seen = 0;
    repeat (15) @(negedge clk);
    #4;
    chk("stream_pops", pops_seen, 16);
    chk("stream_count", q_count, 3);
    pop_mode = 0;
    repeat (8) @(negedge clk);

    // Redirect while the C004 request is outstanding; ack arrives later.
    hold = 1; hold_addr = 16'hC004;
    redirect(16'hC000);
    t = 0;
    do begin @(negedge clk); #2; t++; end while (!(mem_req && mem_addr == 16'hC004) && t < 30);
    chk("wait_c004", mem_req && mem_addr == 16'hC004, 1);
    redir_en = 1; redir_pc = 16'hF001;
    @(negedge clk);
    redir_en = 0;
    #4;
    chk("redir_flush_count", q_count, 0);
    chk("discard_req_held", mem_req, 1);
    chk("discard_addr_held", mem_addr, 16'hC004);
    repeat (2) @(negedge clk);
    hold = 0;
    t = 0;
    do begin @(negedge clk); #2; t++; end while (!q_valid && t < 30);
    chk("redir_first_pc", q_pc, 16'hF000);

    // Redirect coincident with ack and pop.
    pop_mode = 1;
    repeat (4) @(negedge clk);
    t = 0;
    do begin @(negedge clk); #2; t++; end while (!(mem_req && mem_ack && q_valid) && t < 30);
    chk("wait_ack_pop", mem_req && mem_ack && q_valid, 1);
    redir_en = 1; redir_pc = 16'h3000;
    @(negedge clk);
    redir_en = 0;
    #4;
    chk("coinc_count", q_count, 0);
    chk("coinc_req_off", mem_req, 0);
    @(negedge clk);
    #4;
    chk("coinc_next_req", mem_req, 1);
    chk("coinc_next_addr", mem_addr, 16'h3000);

    // Address wrap at the top of memory.
    pop_mode = 0;
    redirect(16'hFFFC);
    t = 0;
    do begin @(negedge clk); #2; t++; end while (q_count != 4 && t < 30);
    chk("wrap_full", q_count, 4);
    pop_mode = 3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      q_pop = 1;
      #4;
      chk("wrap_pc", q_pc, wrap_pcs[i]);
    end
    @(negedge clk);
    q_pop = 0;
    pop_mode = 0;

    // Asynchronous reset with a request outstanding and three entries queued.
    fixed_lat = 2;
    redirect(16'hC000);
    t = 0;
    do begin @(negedge clk); #2; t++; end while (!(q_count == 3 && mem_req) && t < 40);
    chk("wait_cnt3_req", q_count == 3 && mem_req, 1);
    rst_vec = 16'hA001;
    rst = 1;
    #1;
    chk("arst_mem_req", mem_req, 0);
    chk("arst_q_count", q_count, 0);
    chk("arst_q_valid", q_valid, 0);
    chk("arst_mem_addr", mem_addr, 0);
    model_reset(rst_vec);
    repeat (2) @(negedge clk);
    rst = 0;
    fixed_lat = 0;
    t = 0;
    do begin @(negedge clk); #2; t++; end while (!mem_req && t < 10);
    chk("arst_first_addr", mem_addr, 16'hA000);

    // Random traffic: random latency, random pops, occasional redirects.
    lat_rand = 1;
    pop_mode = 2;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      redir_en = ($urandom_range(0, 24) == 0);
      redir_pc = 16'($urandom);
    end
    @(negedge clk);
    redir_en = 0;
    repeat (10) @(negedge clk);
    #4;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
